// File: rtl/ldpc_codeword_serializer_if.sv
// rtl/ldpc_codeword_serializer_if.sv - info, parity and output streams of the LDPC codeword serializer
// master is the producer/consumer side, slave is the serializer.
interface ldpc_codeword_serializer_if #(
  parameter int NUM_Z        = 3,
  parameter int MAX_Z        = 81,
  parameter int NUM_PAR_BLKS = 4,
  parameter int IDXW         = 5,
  parameter int ZW           = 7
);
  logic [NUM_Z-1:0]              req_z;
  logic                          info_valid;
  logic                          info_ready;
  logic [MAX_Z-1:0]              info_data;
  logic                          par_valid;
  logic                          par_ready;
  logic [NUM_PAR_BLKS*MAX_Z-1:0] par_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [MAX_Z-1:0]              out_data;
  logic [IDXW-1:0]               out_blk_idx;
  logic                          out_last;
  logic [ZW-1:0]                 out_z;
  logic                          busy;
  logic                          err;

  modport master (
    output req_z, info_valid, info_data, par_valid, par_data, out_ready,
    input  info_ready, par_ready, out_valid, out_data, out_blk_idx, out_last, out_z, busy, err
  );

  modport slave (
    input  req_z, info_valid, info_data, par_valid, par_data, out_ready,
    output info_ready, par_ready, out_valid, out_data, out_blk_idx, out_last, out_z, busy, err
  );
endinterface

// File: rtl/ldpc_codeword_serializer.sv
// rtl/ldpc_codeword_serializer.sv - streams info blocks then buffered parity blocks as one codeword
// Optional sticky protocol-error flag: define LDPC_SER_ERR_CHECK_EN.
module ldpc_codeword_serializer #(
  parameter int NUM_Z             = 3,
  parameter int Z_VALUES [NUM_Z]  = '{27, 54, 81},
  parameter int MAX_Z             = 81,
  parameter int NUM_INFO_BLKS     = 20,
  parameter int NUM_PAR_BLKS      = 4,
  parameter int TOTAL_BLKS        = NUM_INFO_BLKS + NUM_PAR_BLKS,
  parameter int IDXW              = $clog2(TOTAL_BLKS),
  parameter int ZW                = $clog2(MAX_Z + 1)
) (
  input  logic                     CLK,
  input  logic                     rst_n,
  ldpc_codeword_serializer_if.slave bus
);

  localparam int PCW = $clog2(NUM_PAR_BLKS + 1);
  localparam int PIW = (NUM_PAR_BLKS > 1) ? $clog2(NUM_PAR_BLKS) : 1;

  typedef enum logic [1:0] {IDLE, INFO, WAIT_PAR, EMIT_PAR} state_t;

  state_t           state;
  logic             run_q;
  logic [IDXW-1:0]  info_cnt;
  logic [PCW-1:0]   par_cnt;
  logic [MAX_Z-1:0] par_buf [NUM_PAR_BLKS];
  logic [ZW-1:0]    z_q;
  logic             out_valid_q;
  logic [MAX_Z-1:0] out_data_q;
  logic [IDXW-1:0]  out_idx_q;
  logic             out_last_q;

  logic             load_ok;
  logic             last_par_held;
  logic             info_fire;
  logic             par_fire;
  logic             out_fire;
  logic             start;
  logic [ZW-1:0]    req_z_val;
  logic [IDXW-1:0]  par_idx;

  function automatic logic [MAX_Z-1:0] z_mask(input logic [ZW-1:0] z);
    logic [MAX_Z-1:0] m;
    for (int i = 0; i < MAX_Z; i++) m[i] = (i < int'(z));
    return m;
  endfunction

  always_comb begin
    req_z_val = ZW'(MAX_Z);
    if ($onehot(bus.req_z)) begin
      for (int i = 0; i < NUM_Z; i++) begin
        if (bus.req_z[i]) req_z_val = ZW'(Z_VALUES[i]);
      end
    end
  end

  // The final parity beat may hand over to the next codeword in the same cycle.
  assign load_ok       = !out_valid_q || bus.out_ready;
  assign last_par_held = (state == EMIT_PAR) && (par_cnt == PCW'(NUM_PAR_BLKS));
  assign bus.info_ready = run_q && load_ok && (state == IDLE || state == INFO || last_par_held);
  assign bus.par_ready  = run_q && load_ok && (state == WAIT_PAR);

  assign info_fire = bus.info_valid && bus.info_ready;
  assign par_fire  = bus.par_valid && bus.par_ready;
  assign out_fire  = out_valid_q && bus.out_ready;
  assign start     = info_fire && (state != INFO);
  assign par_idx   = IDXW'(NUM_INFO_BLKS) + IDXW'(par_cnt);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      run_q       <= 1'b0;
      info_cnt    <= '0;
      par_cnt     <= '0;
      z_q         <= ZW'(MAX_Z);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      for (int k = 0; k < NUM_PAR_BLKS; k++) par_buf[k] <= '0;
    end else begin
      run_q <= 1'b1;
      if (start) begin
        z_q         <= req_z_val;
        out_valid_q <= 1'b1;
        out_data_q  <= bus.info_data & z_mask(req_z_val);
        out_idx_q   <= '0;
        out_last_q  <= (TOTAL_BLKS == 1);
        info_cnt    <= IDXW'(1);
        par_cnt     <= '0;
        state       <= (NUM_INFO_BLKS == 1) ? WAIT_PAR : INFO;
      end else begin
        case (state)
          INFO: begin
            if (info_fire) begin
              out_valid_q <= 1'b1;
              out_data_q  <= bus.info_data & z_mask(z_q);
              out_idx_q   <= info_cnt;
              out_last_q  <= 1'b0;
              info_cnt    <= info_cnt + 1'b1;
              if (info_cnt == IDXW'(NUM_INFO_BLKS - 1)) state <= WAIT_PAR;
            end else if (out_fire) begin
              out_valid_q <= 1'b0;
            end
          end
          WAIT_PAR: begin
            if (par_fire) begin
              for (int k = 0; k < NUM_PAR_BLKS; k++) par_buf[k] <= bus.par_data[k*MAX_Z +: MAX_Z];
              out_valid_q <= 1'b1;
              out_data_q  <= bus.par_data[MAX_Z-1:0] & z_mask(z_q);
              out_idx_q   <= IDXW'(NUM_INFO_BLKS);
              out_last_q  <= (NUM_PAR_BLKS == 1);
              par_cnt     <= PCW'(1);
              state       <= EMIT_PAR;
            end else if (out_fire) begin
              out_valid_q <= 1'b0;
            end
          end
          EMIT_PAR: begin
            if (out_fire) begin
              if (last_par_held) begin
                out_valid_q <= 1'b0;
                par_cnt     <= '0;
                info_cnt    <= '0;
                state       <= IDLE;
              end else begin
                out_data_q <= par_buf[PIW'(par_cnt)] & z_mask(z_q);
                out_idx_q  <= par_idx;
                out_last_q <= (par_idx == IDXW'(TOTAL_BLKS - 1));
                par_cnt    <= par_cnt + 1'b1;
              end
            end
          end
          default: begin
            if (out_fire) out_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_blk_idx = out_idx_q;
  assign bus.out_last    = out_last_q;
  assign bus.out_z       = z_q;
  assign bus.busy        = (state != IDLE);

`ifdef LDPC_SER_ERR_CHECK_EN
  logic err_q;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if ((start && !$onehot(bus.req_z)) ||
                 (bus.par_valid && (state == IDLE || state == INFO))) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_ldpc_codeword_serializer.sv
// tb/tb_ldpc_codeword_serializer.sv - directed self-checking bench for ldpc_codeword_serializer
module tb_ldpc_codeword_serializer;
  localparam int MAX_Z = 81;
  localparam int NI    = 20;
  localparam int NP    = 4;
  localparam int TB    = NI + NP;
`ifdef LDPC_SER_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic rst_n;
  always #5 CLK = ~CLK;

  ldpc_codeword_serializer_if bus();
  ldpc_codeword_serializer dut (.CLK(CLK), .rst_n(rst_n), .bus(bus));

  int n_assert = 0;
  int n_fail   = 0;

  logic [MAX_Z-1:0] q_data[$];
  int               q_idx[$];
  logic             q_last[$];
  int               q_z[$];
  int               q_cyc[$];
  int cyc, first_info_cyc, stall_viol, ready_viol, stall_cnt, glitch_ack;

  function automatic logic [MAX_Z-1:0] zmask(input int z);
    logic [MAX_Z-1:0] one;
    one = 81'd1;
    return (one << z) - one;
  endfunction

  function automatic logic [MAX_Z-1:0] info_pat(input int mode, input int cw, input int i);
    logic [MAX_Z-1:0] v;
    if (mode == 0) v = '1;
    else v = {17'(i*977 + cw*31 + 5), 64'h9E37_79B9_7F4A_7C15 ^ 64'(i*64'h0101_0101 + cw)};
    return v;
  endfunction

  function automatic logic [MAX_Z-1:0] par_pat(input int mode, input int cw, input int k);
    logic [MAX_Z-1:0] v;
    if (mode == 0) v = 81'(k + 1);
    else v = {17'(k*4099 + cw*7 + 1), 64'hC3A5_5A3C_0F1E_2D4B ^ 64'(k*3 + cw*11 + 1)};
    return v;
  endfunction

  function automatic logic [MAX_Z-1:0] exp_block(input int cw, input int j, input int z);
    logic [MAX_Z-1:0] raw;
    raw = (j < NI) ? info_pat(1, cw, j) : par_pat(1, cw, j - NI);
    return raw & zmask(z);
  endfunction

  // Producer/consumer loop; entered and left at posedge+1. Records every output beat.
  task automatic drive(input int ncw, input logic [2:0] z0, input logic [2:0] z1, input int mode,
                       input bit rand_ready, input int par_glitch, output bit timed_out);
    int info_sent, par_sent, cw, target;
    bit glitched, glitch_now, prev_stall;
    logic [MAX_Z+5+1+7-1:0] prev_snap;
    q_data.delete(); q_idx.delete(); q_last.delete(); q_z.delete(); q_cyc.delete();
    info_sent = 0; par_sent = 0; glitched = 0; prev_stall = 0; prev_snap = '0;
    cyc = 0; first_info_cyc = -1; stall_viol = 0; ready_viol = 0; stall_cnt = 0; glitch_ack = 0;
    timed_out = 0;
    target = ncw * TB;
    while (q_data.size() < target && !timed_out) begin
      cw = info_sent / NI;
      bus.req_z      = (cw == 0) ? z0 : z1;
      bus.info_valid = (info_sent < NI*(par_sent+1)) && (info_sent < NI*ncw);
      bus.info_data  = info_pat(mode, cw, info_sent % NI);
      bus.par_valid  = (info_sent == NI*(par_sent+1)) && (par_sent < ncw);
      for (int k = 0; k < NP; k++) bus.par_data[k*MAX_Z +: MAX_Z] = par_pat(mode, par_sent, k);
      glitch_now = 0;
      if (!glitched && info_sent > 0 && info_sent == par_glitch && !bus.par_valid) begin
        bus.par_valid = 1'b1;
        bus.par_data  = '1;
        glitch_now    = 1;
        glitched      = 1;
      end
      bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge CLK);
      cyc++;
      if (prev_stall && ({bus.out_valid, bus.out_data, bus.out_blk_idx, bus.out_last, bus.out_z}
                         !== {1'b1, prev_snap})) stall_viol++;
      if (bus.out_valid && !bus.out_ready) begin
        stall_cnt++;
        if (bus.info_ready || bus.par_ready) ready_viol++;
      end
      if (glitch_now && bus.par_ready) glitch_ack++;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_snap  = {bus.out_data, bus.out_blk_idx, bus.out_last, bus.out_z};
      if (bus.info_valid && bus.info_ready) begin
        if (info_sent == 0) first_info_cyc = cyc;
        info_sent++;
      end
      if (bus.par_valid && bus.par_ready && !glitch_now) par_sent++;
      if (bus.out_valid && bus.out_ready) begin
        q_data.push_back(bus.out_data);
        q_idx.push_back(int'(bus.out_blk_idx));
        q_last.push_back(bus.out_last);
        q_z.push_back(int'(bus.out_z));
        q_cyc.push_back(cyc);
      end
      if (cyc > 1000) timed_out = 1;
      @(posedge CLK);
      #1;
    end
    bus.info_valid = 1'b0;
    bus.par_valid  = 1'b0;
    bus.out_ready  = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_z = 3'b001; bus.info_valid = 0; bus.info_data = '0;
    bus.par_valid = 0; bus.par_data = '0; bus.out_ready = 1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    n_assert++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", bus.out_valid); end
    n_assert++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %0h expected 0", bus.out_data); end
    n_assert++; if (bus.out_blk_idx !== 5'd0) begin n_fail++; $display("FAIL reset_idx: got %0d expected 0", bus.out_blk_idx); end
    n_assert++; if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %0b expected 0", bus.out_last); end
    n_assert++; if (bus.out_z !== 7'd81) begin n_fail++; $display("FAIL reset_out_z: got %0d expected 81", bus.out_z); end
    n_assert++; if (bus.info_ready !== 1'b0) begin n_fail++; $display("FAIL reset_info_ready: got %0b expected 0", bus.info_ready); end
    n_assert++; if (bus.par_ready !== 1'b0) begin n_fail++; $display("FAIL reset_par_ready: got %0b expected 0", bus.par_ready); end
    n_assert++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
    n_assert++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b expected 0", bus.err); end
    @(posedge CLK); #1;
    rst_n = 1'b1;
    @(negedge CLK);
    n_assert++; if (bus.info_ready !== 1'b0) begin n_fail++; $display("FAIL release_info_ready_early: got %0b expected 0", bus.info_ready); end
    @(negedge CLK);
    n_assert++; if (bus.info_ready !== 1'b1) begin n_fail++; $display("FAIL release_info_ready: got %0b expected 1", bus.info_ready); end
    @(posedge CLK); #1;
  endtask

  task automatic test_stream_z27();
    bit to;
    logic [MAX_Z-1:0] exp_d;
    drive(1, 3'b001, 3'b001, 0, 0, -1, to);
    n_assert++; if (to !== 1'b0) begin n_fail++; $display("FAIL z27_timeout: got %0b expected 0", to); end
    n_assert++; if (q_data.size() !== 24) begin n_fail++; $display("FAIL z27_beats: got %0d expected 24", q_data.size()); end
    for (int b = 0; b < q_data.size(); b++) begin
      exp_d = (b < 20) ? 81'h7FFFFFF : 81'(b - 19);
      n_assert++; if (q_data[b] !== exp_d) begin n_fail++; $display("FAIL z27_data[%0d]: got %0h expected %0h", b, q_data[b], exp_d); end
      n_assert++; if (q_idx[b] !== b) begin n_fail++; $display("FAIL z27_idx[%0d]: got %0d expected %0d", b, q_idx[b], b); end
      n_assert++; if (q_last[b] !== (b == 23)) begin n_fail++; $display("FAIL z27_last[%0d]: got %0b expected %0b", b, q_last[b], b == 23); end
      n_assert++; if (q_z[b] !== 27) begin n_fail++; $display("FAIL z27_out_z[%0d]: got %0d expected 27", b, q_z[b]); end
    end
    if (q_cyc.size() > 0) begin
      n_assert++; if (q_cyc[$] - first_info_cyc + 1 !== 25) begin n_fail++; $display("FAIL z27_cycles: got %0d expected 25", q_cyc[$] - first_info_cyc + 1); end
    end
    @(negedge CLK);
    n_assert++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL z27_idle_busy: got %0b expected 0", bus.busy); end
    n_assert++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL z27_idle_valid: got %0b expected 0", bus.out_valid); end
    n_assert++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL z27_err: got %0b expected 0", bus.err); end
    @(posedge CLK); #1;
  endtask

  task automatic test_stall_z81();
    bit to;
    logic [MAX_Z-1:0] exp_d;
    drive(1, 3'b100, 3'b100, 1, 1, -1, to);
    n_assert++; if (to !== 1'b0) begin n_fail++; $display("FAIL stall_timeout: got %0b expected 0", to); end
    n_assert++; if (q_data.size() !== 24) begin n_fail++; $display("FAIL stall_beats: got %0d expected 24", q_data.size()); end
    for (int b = 0; b < q_data.size(); b++) begin
      exp_d = exp_block(0, b, 81);
      n_assert++; if (q_data[b] !== exp_d) begin n_fail++; $display("FAIL stall_data[%0d]: got %0h expected %0h", b, q_data[b], exp_d); end
      n_assert++; if (q_idx[b] !== b) begin n_fail++; $display("FAIL stall_idx[%0d]: got %0d expected %0d", b, q_idx[b], b); end
      n_assert++; if (q_z[b] !== 81) begin n_fail++; $display("FAIL stall_out_z[%0d]: got %0d expected 81", b, q_z[b]); end
    end
    n_assert++; if (stall_viol !== 0) begin n_fail++; $display("FAIL stall_hold: got %0d changes expected 0", stall_viol); end
    n_assert++; if (ready_viol !== 0) begin n_fail++; $display("FAIL stall_ready: got %0d ready-while-stalled expected 0", ready_viol); end
    n_assert++; if ((stall_cnt > 0) !== 1'b1) begin n_fail++; $display("FAIL stall_seen: got %0d stalls expected >0", stall_cnt); end
  endtask

  task automatic test_back_to_back();
    bit to;
    int cw, j, z;
    logic [MAX_Z-1:0] exp_d;
    drive(2, 3'b010, 3'b100, 1, 0, -1, to);
    n_assert++; if (to !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout: got %0b expected 0", to); end
    n_assert++; if (q_data.size() !== 48) begin n_fail++; $display("FAIL b2b_beats: got %0d expected 48", q_data.size()); end
    for (int b = 0; b < q_data.size(); b++) begin
      cw = b / TB; j = b % TB; z = (cw == 0) ? 54 : 81;
      exp_d = exp_block(cw, j, z);
      n_assert++; if (q_data[b] !== exp_d) begin n_fail++; $display("FAIL b2b_data[%0d]: got %0h expected %0h", b, q_data[b], exp_d); end
      n_assert++; if (q_idx[b] !== j) begin n_fail++; $display("FAIL b2b_idx[%0d]: got %0d expected %0d", b, q_idx[b], j); end
      n_assert++; if (q_last[b] !== (j == 23)) begin n_fail++; $display("FAIL b2b_last[%0d]: got %0b expected %0b", b, q_last[b], j == 23); end
      n_assert++; if (q_z[b] !== z) begin n_fail++; $display("FAIL b2b_out_z[%0d]: got %0d expected %0d", b, q_z[b], z); end
    end
    if (q_cyc.size() == 48) begin
      n_assert++; if (q_cyc[24] - q_cyc[23] !== 1) begin n_fail++; $display("FAIL b2b_gap: got %0d cycles expected 1", q_cyc[24] - q_cyc[23]); end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int n;
    logic [MAX_Z-1:0] exp_d;
    n = 0;
    bus.req_z = 3'b010; bus.out_ready = 1'b1;
    for (int c = 0; c < 100 && n < 10; c++) begin
      bus.info_valid = 1'b1;
      bus.info_data  = info_pat(1, 0, n);
      @(negedge CLK);
      if (bus.info_valid && bus.info_ready) n++;
      @(posedge CLK); #1;
    end
    n_assert++; if (n !== 10) begin n_fail++; $display("FAIL rmid_accepted: got %0d expected 10", n); end
    bus.info_data = info_pat(1, 0, 10);
    rst_n = 1'b0;
    @(negedge CLK);
    n_assert++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid: got %0b expected 0", bus.out_valid); end
    n_assert++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %0b expected 0", bus.busy); end
    n_assert++; if (bus.out_blk_idx !== 5'd0) begin n_fail++; $display("FAIL rmid_idx: got %0d expected 0", bus.out_blk_idx); end
    @(posedge CLK); #1;
    rst_n = 1'b1;
    bus.info_valid = 1'b0;
    drive(1, 3'b001, 3'b001, 1, 0, -1, to);
    n_assert++; if (to !== 1'b0) begin n_fail++; $display("FAIL rmid_timeout: got %0b expected 0", to); end
    n_assert++; if (q_data.size() !== 24) begin n_fail++; $display("FAIL rmid_beats: got %0d expected 24", q_data.size()); end
    for (int b = 0; b < q_data.size(); b++) begin
      exp_d = exp_block(0, b, 27);
      n_assert++; if (q_data[b] !== exp_d) begin n_fail++; $display("FAIL rmid_data[%0d]: got %0h expected %0h", b, q_data[b], exp_d); end
      n_assert++; if (q_idx[b] !== b) begin n_fail++; $display("FAIL rmid_idx[%0d]: got %0d expected %0d", b, q_idx[b], b); end
      n_assert++; if (q_z[b] !== 27) begin n_fail++; $display("FAIL rmid_out_z[%0d]: got %0d expected 27", b, q_z[b]); end
    end
  endtask

  task automatic test_bad_z();
    bit to;
    logic [MAX_Z-1:0] exp_d;
    drive(1, 3'b011, 3'b011, 1, 0, -1, to);
    n_assert++; if (to !== 1'b0) begin n_fail++; $display("FAIL badz_timeout: got %0b expected 0", to); end
    n_assert++; if (q_data.size() !== 24) begin n_fail++; $display("FAIL badz_beats: got %0d expected 24", q_data.size()); end
    for (int b = 0; b < q_data.size(); b++) begin
      exp_d = exp_block(0, b, 81);
      n_assert++; if (q_data[b] !== exp_d) begin n_fail++; $display("FAIL badz_data[%0d]: got %0h expected %0h", b, q_data[b], exp_d); end
      n_assert++; if (q_z[b] !== 81) begin n_fail++; $display("FAIL badz_out_z[%0d]: got %0d expected 81", b, q_z[b]); end
    end
    @(negedge CLK);
    n_assert++; if (bus.err !== ERR_EN) begin n_fail++; $display("FAIL badz_err: got %0b expected %0b", bus.err, ERR_EN); end
    @(posedge CLK); #1;
  endtask

  task automatic test_par_glitch();
    bit to;
    logic [MAX_Z-1:0] exp_d;
    rst_n = 1'b0;
    @(posedge CLK); #1;
    rst_n = 1'b1;
    @(negedge CLK);
    n_assert++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL glitch_err_cleared: got %0b expected 0", bus.err); end
    @(posedge CLK); #1;
    drive(1, 3'b010, 3'b010, 1, 0, 5, to);
    n_assert++; if (to !== 1'b0) begin n_fail++; $display("FAIL glitch_timeout: got %0b expected 0", to); end
    n_assert++; if (glitch_ack !== 0) begin n_fail++; $display("FAIL glitch_par_ready: got %0d acks expected 0", glitch_ack); end
    n_assert++; if (q_data.size() !== 24) begin n_fail++; $display("FAIL glitch_beats: got %0d expected 24", q_data.size()); end
    for (int b = 0; b < q_data.size(); b++) begin
      exp_d = exp_block(0, b, 54);
      n_assert++; if (q_data[b] !== exp_d) begin n_fail++; $display("FAIL glitch_data[%0d]: got %0h expected %0h", b, q_data[b], exp_d); end
      n_assert++; if (q_idx[b] !== b) begin n_fail++; $display("FAIL glitch_idx[%0d]: got %0d expected %0d", b, q_idx[b], b); end
    end
    @(negedge CLK);
    n_assert++; if (bus.err !== ERR_EN) begin n_fail++; $display("FAIL glitch_err: got %0b expected %0b", bus.err, ERR_EN); end
    @(posedge CLK); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream_z27();
    test_stall_z81();
    test_back_to_back();
    test_reset_mid();
    test_bad_z();
    test_par_glitch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
